// File: rtl/ec_serial_harness_ctrl.sv
// Serial test harness controller for EC arithmetic cores.
// Deserialises an IN_WIDTH-bit frame into core_din, pulses core_start, waits for
// core_done (bounded by a 2^TIMEOUT_W-cycle timer) and serialises a response
// frame {timeout_bit, core_dout} MSB first.
// Optional macro ECSH_CYCLE_CNT_EN: response becomes {timeout_bit, cycles, core_dout},
// where cycles is the WAIT timer value at the decision cycle.
module ec_serial_harness_ctrl #(
    parameter int unsigned IN_WIDTH  = 166,
    parameter int unsigned OUT_WIDTH = 326,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ser_in,
    input  logic                 ser_in_vld,
    output logic                 ser_out,
    output logic                 ser_out_vld,
    output logic                 busy,
    output logic                 timeout,
    output logic                 core_start,
    output logic [IN_WIDTH-1:0]  core_din,
    input  logic                 core_done,
    input  logic [OUT_WIDTH-1:0] core_dout
);

`ifdef ECSH_CYCLE_CNT_EN
    localparam int unsigned FRAME_W = 1 + TIMEOUT_W + OUT_WIDTH;
`else
    localparam int unsigned FRAME_W = 1 + OUT_WIDTH;
`endif
    localparam int unsigned MAX_LEN = (IN_WIDTH > FRAME_W) ? IN_WIDTH : FRAME_W;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {StRx, StStart, StWait, StSend} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    // Holds only the first IN_WIDTH-1 bits; the last bit goes straight into core_din.
    logic [IN_WIDTH-2:0]  in_sr_q, in_sr_d;
    logic [FRAME_W-1:0]   out_sr_q, out_sr_d;
    logic [IN_WIDTH-1:0]  core_din_q, core_din_d;
    logic                 timeout_q, timeout_d;
    logic [IN_WIDTH-1:0]  rx_word;

    assign rx_word = {in_sr_q, ser_in};

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRx;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            in_sr_q    <= '0;
            out_sr_q   <= '0;
            core_din_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            in_sr_q    <= in_sr_d;
            out_sr_q   <= out_sr_d;
            core_din_q <= core_din_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: receive, start, wait for done/timeout, send.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        in_sr_d    = in_sr_q;
        out_sr_d   = out_sr_q;
        core_din_d = core_din_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            StRx: begin
                if (ser_in_vld) begin
                    in_sr_d = rx_word[IN_WIDTH-2:0];
                    if (bit_cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                        core_din_d = rx_word;
                        bit_cnt_d  = '0;
                        state_d    = StStart;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            StStart: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (core_done || (&timer_q)) begin
`ifdef ECSH_CYCLE_CNT_EN
                    out_sr_d = {~core_done, timer_q, core_dout};
`else
                    out_sr_d = {~core_done, core_dout};
`endif
                    // Sticky flag records any run that ended without done.
                    timeout_d = timeout_q | ~core_done;
                    bit_cnt_d = '0;
                    state_d   = StSend;
                end else begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
            end
            StSend: begin
                out_sr_d = {out_sr_q[FRAME_W-2:0], 1'b0};
                if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = StRx;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StRx;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        ser_out     = 1'b0;
        ser_out_vld = 1'b0;
        core_start  = 1'b0;
        busy        = (state_q != StRx);
        if (state_q == StSend) begin
            ser_out     = out_sr_q[FRAME_W-1];
            ser_out_vld = 1'b1;
        end
        if (state_q == StStart) begin
            core_start = 1'b1;
        end
    end

    assign core_din = core_din_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_ec_serial_harness_ctrl.sv
// Directed testbench for ec_serial_harness_ctrl (IN_WIDTH=8, OUT_WIDTH=8, TIMEOUT_W=4).
// A stub core raises core_done on the programmed WAIT cycle (0 = never).
module tb_ec_serial_harness_ctrl;

    localparam int unsigned IN_WIDTH  = 8;
    localparam int unsigned OUT_WIDTH = 8;
    localparam int unsigned TIMEOUT_W = 4;
`ifdef ECSH_CYCLE_CNT_EN
    localparam int FW = 13;
`else
    localparam int FW = 9;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ser_in = 1'b0;
    logic                 ser_in_vld = 1'b0;
    logic                 ser_out;
    logic                 ser_out_vld;
    logic                 busy;
    logic                 timeout;
    logic                 core_start;
    logic [IN_WIDTH-1:0]  core_din;
    logic                 core_done;
    logic [OUT_WIDTH-1:0] core_dout;

    int checks = 0;
    int errors = 0;

    // Stub core state
    int                   done_delay = 0;
    int                   stub_cnt = 0;
    logic                 stub_run = 1'b0;
    logic [OUT_WIDTH-1:0] stub_dout = '0;

    ec_serial_harness_ctrl #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .ser_in_vld (ser_in_vld),
        .ser_out    (ser_out),
        .ser_out_vld(ser_out_vld),
        .busy       (busy),
        .timeout    (timeout),
        .core_start (core_start),
        .core_din   (core_din),
        .core_done  (core_done),
        .core_dout  (core_dout)
    );

    always #5 clk = ~clk;

    // Stub: WAIT cycle n after core_start sees stub_cnt == n.
    always @(posedge clk) begin
        if (core_start) begin
            stub_run <= 1'b1;
            stub_cnt <= 1;
        end else if (stub_run) begin
            if (core_done) stub_run <= 1'b0;
            else stub_cnt <= stub_cnt + 1;
        end
    end
    assign core_done = stub_run && (done_delay != 0) && (stub_cnt == done_delay);
    assign core_dout = stub_dout;

    // Shift a frame MSB first; returns at the negedge where the DUT sits in START.
    task automatic send_frame(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            ser_in     = v[i];
            ser_in_vld = 1'b1;
            if (gaps) begin
                @(negedge clk);
                ser_in     = ~v[i];
                ser_in_vld = 1'b0;
            end
        end
        if (!gaps) begin
            @(negedge clk);
            ser_in_vld = 1'b0;
        end
    endtask

    // Collect the response; pre counts idle busy cycles before the first valid bit.
    task automatic collect(input int budget, output logic [15:0] bits, output int n,
                           output int pre);
        bits = '0;
        n    = 0;
        pre  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ser_out_vld) begin
                bits = {bits[14:0], ser_out};
                n++;
            end else if (n > 0) begin
                break;
            end else begin
                pre++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, timeout, core_start, ser_out, ser_out_vld} !== 5'b0 || core_din !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b din %h want 00000 din 00",
                     {busy, timeout, core_start, ser_out, ser_out_vld}, core_din);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] bits;
        int n, pre;
        done_delay = 3;
        stub_dout  = 8'h3C;
        send_frame(8'hA5, 1'b0);
        checks++;
        if (core_start !== 1'b1 || core_din !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_start got start %b din %h busy %b want 1 a5 1",
                     core_start, core_din, busy);
        end
        collect(40, bits, n, pre);
        checks++;
        if (pre !== 3) begin
            errors++;
            $display("FAIL t2_latency got %0d want 3", pre);
        end
        checks++;
`ifdef ECSH_CYCLE_CNT_EN
        if (n !== FW || bits !== 16'b000_0_0010_00111100) begin
`else
        if (n !== FW || bits !== 16'b0000000_0_00111100) begin
`endif
            errors++;
            $display("FAIL t2_frame got %0d bits %b", n, bits);
        end
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL t2_after got busy %b timeout %b want 0 0", busy, timeout);
        end
    endtask

    task automatic test_gaps_and_busy_ignore();
        logic [15:0] bits;
        int n, pre;
        done_delay = 4;
        stub_dout  = 8'h5A;
        send_frame(8'hA5, 1'b1);
        checks++;
        if (core_start !== 1'b1 || core_din !== 8'hA5) begin
            errors++;
            $display("FAIL t3_gap_din got start %b din %h want 1 a5", core_start, core_din);
        end
        // Extra bits while busy must be dropped.
        @(negedge clk); ser_in = 1'b1; ser_in_vld = 1'b1;
        @(negedge clk); ser_in = 1'b1; ser_in_vld = 1'b1;
        @(negedge clk); ser_in_vld = 1'b0;
        collect(40, bits, n, pre);
        checks++;
`ifdef ECSH_CYCLE_CNT_EN
        if (n !== FW || pre !== 1 || bits !== 16'b000_0_0011_01011010) begin
`else
        if (n !== FW || pre !== 1 || bits !== 16'b0000000_0_01011010) begin
`endif
            errors++;
            $display("FAIL t3_frame got n %0d pre %0d bits %b", n, pre, bits);
        end
        done_delay = 1;
        stub_dout  = 8'hC3;
        send_frame(8'h0F, 1'b0);
        checks++;
        if (core_din !== 8'h0F) begin
            errors++;
            $display("FAIL t3_clean_din got %h want 0f", core_din);
        end
        collect(40, bits, n, pre);
        checks++;
`ifdef ECSH_CYCLE_CNT_EN
        if (n !== FW || pre !== 1 || bits !== 16'b000_0_0000_11000011) begin
`else
        if (n !== FW || pre !== 1 || bits !== 16'b0000000_0_11000011) begin
`endif
            errors++;
            $display("FAIL t3_clean_frame got n %0d pre %0d bits %b", n, pre, bits);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] bits;
        int n, pre;
        done_delay = 0;
        stub_dout  = 8'hFF;
        send_frame(8'h77, 1'b0);
        collect(60, bits, n, pre);
        checks++;
        if (pre !== 16) begin
            errors++;
            $display("FAIL t4_wait_cycles got %0d want 16", pre);
        end
        checks++;
`ifdef ECSH_CYCLE_CNT_EN
        if (n !== FW || bits !== 16'b000_1_1111_11111111) begin
`else
        if (n !== FW || bits !== 16'b0000000_1_11111111) begin
`endif
            errors++;
            $display("FAIL t4_frame got n %0d bits %b", n, bits);
        end
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL t4_flag got %b want 1", timeout);
        end
        done_delay = 2;
        stub_dout  = 8'h00;
        send_frame(8'h11, 1'b0);
        collect(40, bits, n, pre);
        checks++;
`ifdef ECSH_CYCLE_CNT_EN
        if (n !== FW || pre !== 2 || bits !== 16'b000_0_0001_00000000) begin
`else
        if (n !== FW || pre !== 2 || bits !== 16'b0000000_0_00000000) begin
`endif
            errors++;
            $display("FAIL t4_normal_frame got n %0d pre %0d bits %b", n, pre, bits);
        end
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL t4_sticky got %b want 1", timeout);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] bits;
        int n, pre;
        // Reset in WAIT; stub's late done must be ignored afterwards.
        done_delay = 6;
        stub_dout  = 8'h99;
        send_frame(8'h55, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_busy_wait got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, timeout, core_start, ser_out, ser_out_vld} !== 5'b0 || core_din !== 8'h00) begin
            errors++;
            $display("FAIL t5_rst_wait got %b din %h want 00000 din 00",
                     {busy, timeout, core_start, ser_out, ser_out_vld}, core_din);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ser_out_vld !== 1'b0) begin
            errors++;
            $display("FAIL t5_late_done got busy %b vld %b want 0 0", busy, ser_out_vld);
        end
        // Reset in SEND.
        done_delay = 1;
        stub_dout  = 8'hF0;
        send_frame(8'h33, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (ser_out_vld !== 1'b1) begin
            errors++;
            $display("FAIL t5_in_send got %b want 1", ser_out_vld);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, timeout, core_start, ser_out, ser_out_vld} !== 5'b0 || core_din !== 8'h00) begin
            errors++;
            $display("FAIL t5_rst_send got %b din %h want 00000 din 00",
                     {busy, timeout, core_start, ser_out, ser_out_vld}, core_din);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Partial frame then reset: must be discarded.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ser_in     = 1'b1;
            ser_in_vld = 1'b1;
        end
        @(negedge clk);
        ser_in_vld = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        done_delay = 1;
        stub_dout  = 8'h7E;
        send_frame(8'h81, 1'b0);
        checks++;
        if (core_start !== 1'b1 || core_din !== 8'h81) begin
            errors++;
            $display("FAIL t5_din got start %b din %h want 1 81", core_start, core_din);
        end
        @(negedge clk);
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL t5_single_start got %b want 0", core_start);
        end
        collect(40, bits, n, pre);
        checks++;
`ifdef ECSH_CYCLE_CNT_EN
        if (n !== FW || bits !== 16'b000_0_0000_01111110) begin
`else
        if (n !== FW || bits !== 16'b0000000_0_01111110) begin
`endif
            errors++;
            $display("FAIL t5_frame got n %0d bits %b", n, bits);
        end
    endtask

`ifdef ECSH_CYCLE_CNT_EN
    task automatic test_cycle_count();
        logic [15:0] bits;
        int n, pre;
        done_delay = 4;
        stub_dout  = 8'h3C;
        send_frame(8'h42, 1'b0);
        collect(40, bits, n, pre);
        checks++;
        if (n !== 13 || pre !== 4 || bits !== 16'b000_0_0011_00111100) begin
            errors++;
            $display("FAIL t6_cycles got n %0d pre %0d bits %b", n, pre, bits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps_and_busy_ignore();
        test_timeout();
        test_reset_mid_op();
`ifdef ECSH_CYCLE_CNT_EN
        test_cycle_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ec_serial_harness_ctrl.md
Name: ec_serial_harness_ctrl

Overview:
Parametrised serial test harness controller for FPGA synthesis wrappers of EC arithmetic cores such as point multiply, point add and field inverse.
- Deserialises one input frame into the core operand word and pulses the core start.
- Waits for done, with a timeout.
- Captures the result and serialises a status-tagged response frame.
- Sits between the two pins test_i/test_o and any core with start/done handshake.

Parameters:
IN_WIDTH, 166, bits in input frame / core_din width
OUT_WIDTH, 326, core_dout width
TIMEOUT_W, 16, width of WAIT-cycle timer; timeout after 2^TIMEOUT_W WAIT cycles

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ser_in  input  1  serial input bit, MSB of frame first
ser_in_vld  input  1  ser_in qualifier
ser_out  output  1  serial response bit, MSB first
ser_out_vld  output  1  high for each valid response bit
busy  output  1  high in START, WAIT, SEND
timeout  output  1  sticky: a core run timed out since reset
core_start  output  1  one-cycle start pulse to core
core_din  output  IN_WIDTH  operand word; stable from START until next frame completes
core_done  input  1  core completion (pulse or level)
core_dout  input  OUT_WIDTH  core result, valid when core_done=1

Behaviour:
- Reset: async on rst_n low. State=RX. Bit counter, timer, shift registers and core_din are 0. All outputs are 0, including the timeout flag.
- States: RX, START, WAIT, SEND. One-hot or binary encoding is implementer's choice.
- RX:
  - Each cycle with ser_in_vld=1: in_sr <= {in_sr[IN_WIDTH-2:0], ser_in}; bit_cnt++.
  - On the edge accepting bit number IN_WIDTH: core_din <= completed word, bit_cnt <= 0, state <= START.
  - ser_in_vld=0 cycles are ignored, so gaps are legal.
- START: core_start=1 for exactly this cycle; timer <= 0; state <= WAIT. core_done is ignored in START.
- WAIT: core_done is sampled every cycle.
  - core_done=1: out_sr <= {1'b0, core_dout}; state <= SEND.
  - core_done=0 and timer==all-ones: out_sr <= {1'b1, core_dout}; timeout flag <= 1; state <= SEND.
  - Otherwise: timer++.
- SEND: ser_out = out_sr MSB; ser_out_vld=1; shift left one bit per cycle.
  - Runs exactly OUT_WIDTH+1 cycles, then state <= RX.
  - ser_out=0 and ser_out_vld=0 in every other state.
- Latency: core_start is high on the cycle after the last input bit is accepted. The first response bit appears the cycle after done is sampled.
- ser_in and ser_in_vld are ignored while busy. A partial frame cannot start until SEND ends.
- Reset mid-operation, in any state: immediate return to reset values. A partial input frame is discarded. A core_done arriving after reset is ignored.
- The timeout flag is cleared only by reset. Each response frame carries its own per-run timeout bit.
- Minimum IN_WIDTH=2, OUT_WIDTH=1, TIMEOUT_W=2. Bit counter width is $clog2(max(IN_WIDTH, OUT_WIDTH+1)+1).

Optional Feature:
Macro ECSH_CYCLE_CNT_EN.
- Defined:
  - Response frame is {timeout_bit, cycles[TIMEOUT_W-1:0], core_dout}, i.e. 1+TIMEOUT_W+OUT_WIDTH bits.
  - cycles is the timer value in the WAIT cycle where done or timeout was decided: done on the first WAIT cycle gives 0; timeout gives all-ones.
  - SEND runs 1+TIMEOUT_W+OUT_WIDTH cycles.
- Undefined: frame is {timeout_bit, core_dout}, and no cycle field is stored.

Test Plan:
Bench parameters: IN_WIDTH=8, OUT_WIDTH=8, TIMEOUT_W=4. Stub core with programmable done delay.
1. Shift 0xA5 MSB first, ser_in_vld held 1 -> cycle after 8th bit: core_din=0xA5 and core_start=1 for 1 cycle; busy=1.
2. Stub asserts core_done on 3rd WAIT cycle with core_dout=0x3C -> next cycle ser_out_vld=1 for 9 cycles, bits 0,0,0,1,1,1,1,0,0; then busy=0 and the timeout flag stays 0.
3. Same 0xA5 frame with ser_in_vld toggling 1,0,1,0..., plus extra bits 1,1 driven while busy -> core_din=0xA5; extra bits ignored; the next clean frame 0x0F yields core_din=0x0F.
4. Stub never asserts done, core_dout=0xFF -> after 16 WAIT cycles the response is 1,1,1,1,1,1,1,1,1; the timeout flag is 1 and stays 1 through a following normal run, whose frame MSB is 0.
5. Assert rst_n=0 in WAIT, then in SEND -> all outputs 0 immediately; after release, frame 0x81 gives core_din=0x81 with a single core_start.
6. With ECSH_CYCLE_CNT_EN, done on 4th WAIT cycle with core_dout=0x3C -> 13-bit response 0,0011,00111100.
